// File: rtl/fastram_refresh_arbiter_if.sv
// fastram_refresh_arbiter_if: request and DRAM strobe bundle between address decode and the FastRAM arbiter
interface fastram_refresh_arbiter_if #(
  parameter int PW = 3
);
  logic          REQ;
  logic          REQ_U;
  logic          REQ_L;
  logic          ACK;
  logic          RASn;
  logic          UCASn;
  logic          LCASn;
  logic          ROW_SEL;
  logic [PW-1:0] REF_PENDING;
  logic          REF_OVF;
  modport master (
    output REQ, REQ_U, REQ_L,
    input  ACK, RASn, UCASn, LCASn, ROW_SEL, REF_PENDING, REF_OVF
  );
  modport slave (
    input  REQ, REQ_U, REQ_L,
    output ACK, RASn, UCASn, LCASn, ROW_SEL, REF_PENDING, REF_OVF
  );
endinterface

// File: rtl/fastram_refresh_arbiter.sv
// fastram_refresh_arbiter: FastRAM RAS/CAS sequencer for CPU accesses and queued CAS-before-RAS refreshes
// Build option REFRESH_BURST_EN: defer refreshes behind CPU traffic (queue up to MAX_PENDING); otherwise single flag.
module fastram_refresh_arbiter #(
  parameter  int REFRESH_INTERVAL = 110,
  parameter  int MAX_PENDING      = 4,
  parameter  int T_RAS_REF        = 2,
  parameter  int T_RP             = 1,
  localparam int PW               = $clog2(MAX_PENDING + 1)
) (
  input logic                      CLK,
  input logic                      RESET,
  fastram_refresh_arbiter_if.slave bus
);
`ifdef REFRESH_BURST_EN
  localparam int MAXP = MAX_PENDING;
`else
  localparam int MAXP = 1;
`endif
  localparam int TW = $clog2(REFRESH_INTERVAL);
  localparam int CW = $clog2((T_RAS_REF > T_RP ? T_RAS_REF : T_RP) + 1);
  typedef enum logic [2:0] {IDLE, ACC_RAS, ACC_CAS, REF_CAS, REF_RAS, PRE} state_t;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic          ack_q, ack_d;
  logic          ras_n_q, ras_n_d;
  logic          ucas_n_q, ucas_n_d;
  logic          lcas_n_q, lcas_n_d;
  logic          row_sel_q, row_sel_d;
  logic          tick, dec, full;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick    = timer_q == TW'(REFRESH_INTERVAL - 1);
    timer_d = tick ? '0 : timer_q + 1'b1;
    dec     = state_q == REF_CAS;
    full    = pend_q == PW'(MAXP);
    unique case (state_q)
`ifdef REFRESH_BURST_EN
      IDLE:    state_d = full ? REF_CAS : bus.REQ ? ACC_RAS : pend_q != '0 ? REF_CAS : IDLE;
`else
      IDLE:    state_d = pend_q != '0 ? REF_CAS : bus.REQ ? ACC_RAS : IDLE;
`endif
      ACC_RAS: state_d = bus.REQ ? ACC_CAS : PRE;
      ACC_CAS: state_d = bus.REQ ? ACC_CAS : PRE;
      REF_CAS: state_d = REF_RAS;
      REF_RAS: begin
        state_d = cnt_q == CW'(T_RAS_REF - 1) ? PRE : REF_RAS;
        cnt_d   = cnt_q == CW'(T_RAS_REF - 1) ? '0 : cnt_q + 1'b1;
      end
      PRE: begin
        state_d = cnt_q == CW'(T_RP - 1) ? IDLE : PRE;
        cnt_d   = cnt_q == CW'(T_RP - 1) ? '0 : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    pend_d    = (tick && !dec) ? (full ? pend_q : pend_q + 1'b1) : (dec && !tick) ? pend_q - 1'b1 : pend_q;
    ovf_d     = ovf_q | (tick & ~dec & full);
    ack_d     = state_q == ACC_RAS && state_d == ACC_CAS;
    ras_n_d   = !(state_d inside {ACC_RAS, ACC_CAS, REF_RAS});
    ucas_n_d  = state_d == ACC_CAS ? ~bus.REQ_U : !(state_d inside {REF_CAS, REF_RAS});
    lcas_n_d  = state_d == ACC_CAS ? ~bus.REQ_L : !(state_d inside {REF_CAS, REF_RAS});
    row_sel_d = state_d != ACC_CAS;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      cnt_q     <= '0;
      pend_q    <= '0;
      ovf_q     <= 1'b0;
      ack_q     <= 1'b0;
      ras_n_q   <= 1'b1;
      ucas_n_q  <= 1'b1;
      lcas_n_q  <= 1'b1;
      row_sel_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      ack_q     <= ack_d;
      ras_n_q   <= ras_n_d;
      ucas_n_q  <= ucas_n_d;
      lcas_n_q  <= lcas_n_d;
      row_sel_q <= row_sel_d;
    end
  end
  assign bus.ACK         = ack_q;
  assign bus.RASn        = ras_n_q;
  assign bus.UCASn       = ucas_n_q;
  assign bus.LCASn       = lcas_n_q;
  assign bus.ROW_SEL     = row_sel_q;
  assign bus.REF_PENDING = pend_q;
  assign bus.REF_OVF     = ovf_q;
endmodule

// File: tb/tb_fastram_refresh_arbiter.sv
// tb_fastram_refresh_arbiter: directed and random stimulus against an operation/phase reference model
module tb_fastram_refresh_arbiter;
  localparam int RI = 16, MP = 4, TRAS = 2, TRP = 1, PW = 3;
`ifdef REFRESH_BURST_EN
  localparam bit BURST = 1'b1;
  localparam int MAXP  = MP;
`else
  localparam bit BURST = 1'b0;
  localparam int MAXP  = 1;
`endif
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  fastram_refresh_arbiter_if #(.PW(PW)) bus();
  fastram_refresh_arbiter #(
    .REFRESH_INTERVAL(RI), .MAX_PENDING(MP), .T_RAS_REF(TRAS), .T_RP(TRP)
  ) dut (.CLK(clk), .RESET(rst), .bus(bus));
  int checks = 0, errors = 0;
  // model: op 0 idle, 1 access, 2 refresh, 3 precharge; age = cycles spent in that op
  int m_op, m_age, m_pend, m_tmr;
  bit m_ovf, m_u, m_l;
  logic [8:0] o;
  function automatic void model(input bit r, u, l, rs);
    bit tick, dec, take_ref;
    m_u = u;
    m_l = l;
    if (rs) begin
      m_op = 0; m_age = 0; m_pend = 0; m_tmr = 0; m_ovf = 0;
      return;
    end
    tick   = m_tmr == RI - 1;
    m_tmr  = tick ? 0 : m_tmr + 1;
    dec    = m_op == 2 && m_age == 0;
    case (m_op)
      0: begin
        take_ref = BURST ? (m_pend == MAXP || (!r && m_pend > 0)) : m_pend > 0;
        if (take_ref) begin m_op = 2; m_age = 0; end
        else if (r) begin m_op = 1; m_age = 0; end
      end
      1: if (!r) begin m_op = 3; m_age = 0; end else m_age = m_age < 2 ? m_age + 1 : 2;
      2: begin m_age++; if (m_age == 1 + TRAS) begin m_op = 3; m_age = 0; end end
      default: begin m_age++; if (m_age == TRP) begin m_op = 0; m_age = 0; end end
    endcase
    if (tick && !dec) begin
      if (m_pend == MAXP) m_ovf = 1; else m_pend++;
    end else if (dec && !tick) m_pend--;
  endfunction
  function automatic logic [8:0] expv();
    bit cas_acc, refr;
    cas_acc = m_op == 1 && m_age >= 1;
    refr    = m_op == 2;
    return {m_op == 1 && m_age == 1,
            !(m_op == 1 || (refr && m_age >= 1)),
            cas_acc ? ~m_u : !refr,
            cas_acc ? ~m_l : !refr,
            !cas_acc,
            PW'(m_pend),
            m_ovf};
  endfunction
  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask
  task automatic step(input bit r, u, l, rs);
    @(negedge clk);
    bus.REQ = r; bus.REQ_U = u; bus.REQ_L = l; rst = rs;
    @(posedge clk);
    model(r, u, l, rs);
    #1;
    o = {bus.ACK, bus.RASn, bus.UCASn, bus.LCASn, bus.ROW_SEL, bus.REF_PENDING, bus.REF_OVF};
    chk("model", o, expv());
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask
  initial begin
    bit r, u, l;
    rst = 1'b1; bus.REQ = 1'b0; bus.REQ_U = 1'b0; bus.REQ_L = 1'b0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("reset", o, 9'b0_1111_000_0);
    idle(16);
    chk("t1_pend1", 9'(o[3:1]), 9'd1);
    idle(1);
    chk("t1_refcas", 9'(o[7:5]), 9'b100);
    idle(1);
    chk("t1_refras_a", 9'(o[7:5]), 9'b000);
    idle(1);
    chk("t1_refras_b", 9'(o[7:5]), 9'b000);
    idle(1);
    chk("t1_pre", {4'b0, o[7:4], o[3:1] != 3'd0}, 9'b0000_1111_0);
    idle(1);
    step(1, 1, 0, 0);
    chk("t2_ras", 9'(o[8:4]), 9'b0_0111);
    step(1, 1, 0, 0);
    chk("t2_cas", 9'(o[8:4]), 9'b1_0010);
    step(1, 1, 0, 0);
    chk("t2_ack_once", 9'(o[8]), 9'd0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("t2_pre", 9'(o[7:4]), 9'b1111);
    idle(2);
    step(0, 0, 0, 1);
    for (int i = 0; i < 28; i++) step(1, 1, 1, 0);
    idle(3);
    step(0, 0, 0, 0);
    chk("t5_tick_dec", 9'(o[3:0]), 9'b0010);
    idle(6);
    step(0, 0, 0, 1);
    step(1, 1, 1, 0);
    step(0, 0, 0, 0);
    chk("t5_abort", 9'(o[8:5]), 9'b0111);
    idle(2);
    step(0, 0, 0, 1);
    idle(18);
    step(0, 0, 0, 1);
    chk("t6_rst_ref", o, 9'b0_1111_000_0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 1);
    chk("t6_rst_acc", o, 9'b0_1111_000_0);
    idle(16);
    chk("t6_timer", 9'(o[3:1]), 9'd1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 80; i++) step(1, 1, 1, 0);
    idle(20);
    step(0, 0, 0, 1);
    for (int i = 0; i < 96; i++) step(1, 0, 1, 0);
    chk("t4_ovf", 9'(o[0]), 9'd1);
    chk("t4_pend", 9'(o[3:1]), 9'(MAXP));
    idle(30);
    chk("t4_drained", 9'(o[3:1]), 9'd0);
    r = 0; u = 0; l = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) begin
        r = ~r;
        u = 1'($urandom);
        l = 1'($urandom);
      end
      step(r, u, l, $urandom_range(699) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
